mmio_uart_tx_responder: RTL and testbench

//   Memory-mapped peripheral that responds to EU data-bus accesses (MEM_* lines) alongside MemoryUnit.
//   CPU stores to TXDATA are buffered in a FIFO and serialised out as 8N1 UART frames.

---
 rtl/mmio_uart_tx_responder.sv | 199 +++++++++++++++++++
 tb/tb_mmio_uart_tx_responder.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx_responder.sv
// Memory-mapped UART transmitter with a TX FIFO, an LED GPIO register and a status word.
// Decodes four word addresses starting at BASE_ADDR on the EU data bus.
module mmio_uart_tx_responder #(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        PLClock,
    input  logic        PLResetN,
    input  logic [15:0] MEM_AddressLine,
    input  logic [15:0] MEM_WriteLine,
    input  logic        MEM_WriteSignal,
    output logic [15:0] MEM_ReadLine,
    output logic        PeriphHit,
    output logic        TxSerial,
    output logic [7:0]  LED,
    output logic [1:0]  dbgState
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

    txState_t         state;
    logic             wrPrev;
    logic             wrStrobe;
    logic [15:0]      offset;
    logic [1:0]       regSel;
    logic             wrTx, wrStatus, wrLed, wrBaud;
    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic [15:0]      baudDiv;
    logic [15:0]      effDiv;
    logic [15:0]      curDiv;
    logic [15:0]      divCnt;
    logic [2:0]       bitCnt;
    logic [7:0]       shiftReg;
    logic             fifoEmpty, fifoFull, busy, lastTick;
    logic             pop, pushOk, pushDrop;
    logic [15:0]      statusWord;

    always_comb begin
        offset    = MEM_AddressLine - BASE_ADDR;
        PeriphHit = (offset < 16'd4);
        regSel    = offset[1:0];
        wrStrobe  = MEM_WriteSignal & ~wrPrev;
        wrTx      = wrStrobe && PeriphHit && (regSel == 2'd0);
        wrStatus  = wrStrobe && PeriphHit && (regSel == 2'd1);
        wrLed     = wrStrobe && PeriphHit && (regSel == 2'd2);
        wrBaud    = wrStrobe && PeriphHit && (regSel == 2'd3);
    end

    always_comb begin
        fifoEmpty  = (count == '0);
        fifoFull   = (count == CNT_W'(FIFO_DEPTH));
        busy       = (state != IDLE);
        lastTick   = (divCnt == 16'd0);
        effDiv     = (baudDiv == 16'd0) ? 16'd1 : baudDiv;
        // The FSM takes the head byte when idle, or at the last cycle of a stop bit.
        pop        = !fifoEmpty && ((state == IDLE) || ((state == STOP) && lastTick));
        pushOk     = wrTx && (!fifoFull || pop);
        pushDrop   = wrTx && !pushOk;
        statusWord = {9'b0, ovf, 3'(count), busy, fifoEmpty, fifoFull};
        dbgState   = state;
    end

    always_comb begin
        MEM_ReadLine = 16'h0000;
        if (PeriphHit) begin
            case (regSel)
                2'd1:    MEM_ReadLine = statusWord;
                2'd2:    MEM_ReadLine = {8'h00, LED};
                2'd3:    MEM_ReadLine = baudDiv;
                default: MEM_ReadLine = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge PLClock) begin
        if (pushOk) begin
            fifoMem[wrPtr] <= MEM_WriteLine[7:0];
        end
    end

    always_ff @(posedge PLClock or negedge PLResetN) begin
        if (!PLResetN) begin
            wrPrev  <= 1'b0;
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            LED     <= 8'h00;
            baudDiv <= 16'(CLKS_PER_BIT);
        end else begin
            wrPrev <= MEM_WriteSignal;
            if (pushOk) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (pushOk && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!pushOk && pop) begin
                count <= count - CNT_W'(1);
            end
            // A drop in the same cycle as a STATUS write leaves OVF set.
            if (pushDrop) begin
                ovf <= 1'b1;
            end else if (wrStatus) begin
                ovf <= 1'b0;
            end
            if (wrLed) begin
                LED <= MEM_WriteLine[7:0];
            end
            if (wrBaud) begin
                baudDiv <= MEM_WriteLine;
            end
        end
    end

    always_ff @(posedge PLClock or negedge PLResetN) begin
        if (!PLResetN) begin
            state    <= IDLE;
            TxSerial <= 1'b1;
            divCnt   <= 16'd0;
            curDiv   <= 16'd1;
            bitCnt   <= 3'd0;
            shiftReg <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    TxSerial <= 1'b1;
                    if (pop) begin
                        shiftReg <= fifoMem[rdPtr];
                        curDiv   <= effDiv;
                        divCnt   <= effDiv - 16'd1;
                        TxSerial <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (lastTick) begin
                        TxSerial <= shiftReg[0];
                        shiftReg <= shiftReg >> 1;
                        bitCnt   <= 3'd0;
                        divCnt   <= curDiv - 16'd1;
                        state    <= DATA;
                    end else begin
                        divCnt <= divCnt - 16'd1;
                    end
                end
                DATA: begin
                    if (lastTick) begin
                        divCnt <= curDiv - 16'd1;
                        if (bitCnt == 3'd7) begin
                            TxSerial <= 1'b1;
                            state    <= STOP;
                        end else begin
                            bitCnt   <= bitCnt + 3'd1;
                            TxSerial <= shiftReg[0];
                            shiftReg <= shiftReg >> 1;
                        end
                    end else begin
                        divCnt <= divCnt - 16'd1;
                    end
                end
                STOP: begin
                    if (lastTick) begin
                        if (pop) begin
                            shiftReg <= fifoMem[rdPtr];
                            curDiv   <= effDiv;
                            divCnt   <= effDiv - 16'd1;
                            TxSerial <= 1'b0;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        divCnt <= divCnt - 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    TxSerial <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx_responder.sv
// Bench for mmio_uart_tx_responder: bus-driven scenarios checked against a FIFO/frame model
// and a line decoder that rebuilds bytes from TxSerial.
module tb_mmio_uart_tx_responder;

    localparam logic [15:0] A_TX   = 16'hFF00;
    localparam logic [15:0] A_ST   = 16'hFF01;
    localparam logic [15:0] A_LED  = 16'hFF02;
    localparam logic [15:0] A_BAUD = 16'hFF03;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic        wsig = 1'b0;
    logic [15:0] rdata;
    logic        hit;
    logic        tx;
    logic [7:0]  led;
    logic [1:0]  dbgState;

    int testsRun = 0;
    int testsFailed = 0;
    int cycCnt = 0;

    mmio_uart_tx_responder dut (
        .PLClock         (clk),
        .PLResetN        (rstN),
        .MEM_AddressLine (addr),
        .MEM_WriteLine   (wdata),
        .MEM_WriteSignal (wsig),
        .MEM_ReadLine    (rdata),
        .PeriphHit       (hit),
        .TxSerial        (tx),
        .LED             (led),
        .dbgState        (dbgState)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycCnt++;

    // Line decoder: finds a start bit, samples each bit at its centre, records byte and start cycle.
    int          monDiv = 16;
    bit          monEn = 1'b0;
    int          monErr = 0;
    logic [7:0]  monByte;
    int          monStart;
    logic [7:0]  got_q[$];
    int          start_q[$];
    logic [7:0]  exp_q[$];

    always begin
        @(negedge clk);
        if (monEn && tx === 1'b0) begin
            monStart = cycCnt;
            repeat (monDiv / 2) @(negedge clk);
            if (tx !== 1'b0) monErr++;
            for (int k = 0; k < 8; k++) begin
                repeat (monDiv) @(negedge clk);
                monByte[k] = tx;
            end
            repeat (monDiv) @(negedge clk);
            if (tx !== 1'b1) monErr++;
            got_q.push_back(monByte);
            start_q.push_back(monStart);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic busWrite(input logic [15:0] a, input logic [15:0] d, input int hold);
        addr = a;
        wdata = d;
        wsig = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        wsig = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clearMon();
        got_q.delete();
        start_q.delete();
        exp_q.delete();
        monErr = 0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        addr = A_ST;
        wsig = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;
        @(negedge clk);
        testsRun++;
        if (rdata !== 16'h0002) begin
            testsFailed++;
            $display("FAIL reset_status: got %h expected %h", rdata, 16'h0002);
        end
        testsRun++;
        if (tx !== 1'b1 || led !== 8'h00) begin
            testsFailed++;
            $display("FAIL reset_outputs: tx %b led %h expected tx 1 led 00", tx, led);
        end
        testsRun++;
        if (hit !== 1'b1) begin
            testsFailed++;
            $display("FAIL reset_hit: got %b expected 1", hit);
        end
        addr = A_BAUD;
        #1;
        testsRun++;
        if (rdata !== 16'd16) begin
            testsFailed++;
            $display("FAIL reset_baud: got %0d expected 16", rdata);
        end
        addr = A_TX;
        #1;
        testsRun++;
        if (rdata !== 16'h0000) begin
            testsFailed++;
            $display("FAIL txdata_read: got %h expected 0000", rdata);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        int bitIdx;
        logic expBit;
        int waveBad, busyBad;
        b = 8'hA5;
        waveBad = 0;
        busyBad = 0;
        clearMon();
        monDiv = 16;
        monEn = 1'b1;
        @(posedge clk);
        #1;
        addr = A_TX;
        wdata = {8'h00, b};
        wsig = 1'b1;
        @(posedge clk);
        #1;
        wsig = 1'b0;
        addr = A_ST;
        @(negedge clk);
        testsRun++;
        if (tx !== 1'b1 || rdata !== 16'h0008) begin
            testsFailed++;
            $display("FAIL frame_latency: tx %b status %h expected tx 1 status 0008", tx, rdata);
        end
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            bitIdx = i / 16;
            if (bitIdx == 0) expBit = 1'b0;
            else if (bitIdx == 9) expBit = 1'b1;
            else expBit = b[bitIdx-1];
            if (tx !== expBit && waveBad == 0) begin
                waveBad = 1;
                $display("FAIL frame_wave: cycle %0d got %b expected %b", i, tx, expBit);
            end
            if (rdata[2] !== 1'b1 && busyBad == 0) begin
                busyBad = 1;
                $display("FAIL frame_busy: cycle %0d got %b expected 1", i, rdata[2]);
            end
        end
        testsRun += 2;
        testsFailed += waveBad + busyBad;
        @(negedge clk);
        testsRun++;
        if (tx !== 1'b1 || rdata !== 16'h0002) begin
            testsFailed++;
            $display("FAIL frame_end: tx %b status %h expected tx 1 status 0002", tx, rdata);
        end
        testsRun++;
        if (got_q.size() != 1 || got_q[0] !== b) begin
            testsFailed++;
            $display("FAIL frame_decode: got %0d bytes first %h expected 1 byte %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, b);
        end
    endtask

    task automatic test_long_strike();
        clearMon();
        monDiv = 16;
        @(posedge clk);
        #1;
        busWrite(A_TX, 16'h003C, 50);
        repeat (200) @(posedge clk);
        #1;
        addr = A_ST;
        #1;
        testsRun++;
        if (got_q.size() != 1 || got_q[0] !== 8'h3C || monErr != 0) begin
            testsFailed++;
            $display("FAIL long_strike: got %0d bytes first %h framing errs %0d expected 1 byte 3c",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, monErr);
        end
        testsRun++;
        if (rdata !== 16'h0002) begin
            testsFailed++;
            $display("FAIL long_strike_status: got %h expected 0002", rdata);
        end
    endtask

    task automatic test_fill_overflow(input int iter);
        int d, md, n, nMax, accepted, drops, inFifo, gapBad, dataBad;
        logic [7:0] b;
        logic [15:0] expStatus;
        if (iter == 0) begin
            d = 4;
            n = 6;
        end else begin
            d = $urandom_range(0, 6);
            md = (d == 0) ? 1 : d;
            nMax = (5 * md - 1 < 8) ? 5 * md - 1 : 8;
            n = $urandom_range(1, nMax);
        end
        md = (d == 0) ? 1 : d;
        clearMon();
        monDiv = md;
        @(posedge clk);
        #1;
        busWrite(A_BAUD, 16'(d), 1);
        addr = A_BAUD;
        #1;
        testsRun++;
        if (rdata !== 16'(d)) begin
            testsFailed++;
            $display("FAIL baud_readback: got %0d expected %0d", rdata, d);
        end
        accepted = 0;
        drops = 0;
        for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            if (accepted < DEPTH + 1) begin
                exp_q.push_back(b);
                accepted++;
            end else begin
                drops++;
            end
            busWrite(A_TX, {8'($urandom), b}, 1);
        end
        inFifo = accepted - 1;
        expStatus = 16'(((drops > 0) ? 64 : 0) + inFifo * 8 + 4 +
                        ((inFifo == 0) ? 2 : 0) + ((inFifo == DEPTH) ? 1 : 0));
        addr = A_ST;
        #1;
        testsRun++;
        if (rdata !== expStatus) begin
            testsFailed++;
            $display("FAIL fill_status[%0d]: got %h expected %h (div %0d writes %0d)",
                     iter, rdata, expStatus, d, n);
        end
        busWrite(A_ST, 16'($urandom), 1);
        expStatus = expStatus & 16'hFFBF;
        addr = A_ST;
        #1;
        testsRun++;
        if (rdata !== expStatus) begin
            testsFailed++;
            $display("FAIL ovf_clear[%0d]: got %h expected %h", iter, rdata, expStatus);
        end
        repeat (accepted * 10 * md + 10) @(posedge clk);
        #1;
        testsRun++;
        if (got_q.size() != exp_q.size() || monErr != 0) begin
            testsFailed++;
            $display("FAIL frame_count[%0d]: got %0d bytes (framing errs %0d) expected %0d",
                     iter, got_q.size(), monErr, exp_q.size());
        end
        dataBad = 0;
        gapBad = 0;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            if (got_q[k] !== exp_q[k] && dataBad == 0) begin
                dataBad = 1;
                $display("FAIL frame_data[%0d]: byte %0d got %h expected %h", iter, k, got_q[k], exp_q[k]);
            end
            if (k > 0 && (start_q[k] - start_q[k-1]) != 10 * md && gapBad == 0) begin
                gapBad = 1;
                $display("FAIL frame_gap[%0d]: byte %0d spacing %0d expected %0d",
                         iter, k, start_q[k] - start_q[k-1], 10 * md);
            end
        end
        testsRun += 2;
        testsFailed += dataBad + gapBad;
        testsRun++;
        if (rdata !== 16'h0002) begin
            testsFailed++;
            $display("FAIL fill_idle[%0d]: got %h expected 0002", iter, rdata);
        end
    endtask

    task automatic test_push_pop_same();
        int pushCyc, bound, dataBad;
        logic [7:0] b;
        clearMon();
        monDiv = 4;
        @(posedge clk);
        #1;
        busWrite(A_BAUD, 16'd4, 1);
        b = 8'($urandom);
        exp_q.push_back(b);
        addr = A_TX;
        wdata = {8'h00, b};
        wsig = 1'b1;
        @(posedge clk);
        #1;
        pushCyc = cycCnt;
        wsig = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < DEPTH; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            busWrite(A_TX, {8'h00, b}, 1);
        end
        // Raise the strike so it lands on the edge where the first frame ends and pops.
        bound = 0;
        while (cycCnt < pushCyc + 40 && bound < 100) begin
            @(posedge clk);
            #1;
            bound++;
        end
        b = 8'($urandom);
        exp_q.push_back(b);
        addr = A_TX;
        wdata = {8'h00, b};
        wsig = 1'b1;
        @(posedge clk);
        #1;
        wsig = 1'b0;
        addr = A_ST;
        #1;
        testsRun++;
        if (rdata !== 16'h0025) begin
            testsFailed++;
            $display("FAIL push_pop_status: got %h expected 0025", rdata);
        end
        repeat (5 * 40 + 20) @(posedge clk);
        #1;
        testsRun++;
        if (got_q.size() != exp_q.size() || monErr != 0) begin
            testsFailed++;
            $display("FAIL push_pop_count: got %0d bytes (framing errs %0d) expected %0d",
                     got_q.size(), monErr, exp_q.size());
        end
        dataBad = 0;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            if (got_q[k] !== exp_q[k] && dataBad == 0) begin
                dataBad = 1;
                $display("FAIL push_pop_data: byte %0d got %h expected %h", k, got_q[k], exp_q[k]);
            end
        end
        testsRun++;
        testsFailed += dataBad;
    endtask

    task automatic test_led_decode();
        logic [15:0] v;
        logic [7:0] ledBefore;
        @(posedge clk);
        #1;
        busWrite(A_LED, 16'h12C3, 1);
        addr = A_LED;
        #1;
        testsRun++;
        if (led !== 8'hC3 || rdata !== 16'h00C3) begin
            testsFailed++;
            $display("FAIL led_write: led %h read %h expected led c3 read 00c3", led, rdata);
        end
        v = 16'($urandom);
        busWrite(A_LED, v, 1);
        addr = A_LED;
        #1;
        testsRun++;
        if (led !== v[7:0] || rdata !== {8'h00, v[7:0]}) begin
            testsFailed++;
            $display("FAIL led_random: led %h read %h expected %h", led, rdata, v[7:0]);
        end
        addr = 16'hFF04;
        #1;
        testsRun++;
        if (hit !== 1'b0 || rdata !== 16'h0000) begin
            testsFailed++;
            $display("FAIL decode_above: hit %b read %h expected hit 0 read 0000", hit, rdata);
        end
        addr = 16'hFEFF;
        #1;
        testsRun++;
        if (hit !== 1'b0 || rdata !== 16'h0000) begin
            testsFailed++;
            $display("FAIL decode_below: hit %b read %h expected hit 0 read 0000", hit, rdata);
        end
        ledBefore = led;
        busWrite(16'hFF06, ~{8'h00, ledBefore}, 1);
        testsRun++;
        if (led !== ledBefore) begin
            testsFailed++;
            $display("FAIL decode_write_ignored: led %h expected %h", led, ledBefore);
        end
        v = 16'($urandom_range(0, 65535));
        busWrite(A_BAUD, v, 1);
        addr = A_BAUD;
        #1;
        testsRun++;
        if (rdata !== v) begin
            testsFailed++;
            $display("FAIL baud_full_width: got %h expected %h", rdata, v);
        end
    endtask

    task automatic test_reset_midframe();
        int stuck;
        clearMon();
        monEn = 1'b0;
        @(posedge clk);
        #1;
        busWrite(A_BAUD, 16'd5, 1);
        busWrite(A_TX, 16'h0000, 1);
        busWrite(A_TX, 16'h00FF, 1);
        repeat (6) @(posedge clk);
        #1;
        addr = A_ST;
        #1;
        testsRun++;
        if (tx !== 1'b0) begin
            testsFailed++;
            $display("FAIL midframe_pre: tx %b expected 0 during data bits", tx);
        end
        #2;
        rstN = 1'b0;
        #1;
        testsRun++;
        if (tx !== 1'b1 || rdata !== 16'h0002) begin
            testsFailed++;
            $display("FAIL midframe_reset: tx %b status %h expected tx 1 status 0002", tx, rdata);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        addr = A_BAUD;
        #1;
        testsRun++;
        if (rdata !== 16'd16) begin
            testsFailed++;
            $display("FAIL midframe_baud: got %0d expected 16", rdata);
        end
        stuck = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) stuck++;
        end
        testsRun++;
        if (stuck != 0) begin
            testsFailed++;
            $display("FAIL midframe_flushed: line low for %0d cycles expected 0", stuck);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_long_strike();
        for (int it = 0; it < 4; it++) begin
            test_fill_overflow(it);
        end
        test_push_pop_same();
        test_led_decode();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
